nand3_sweep_checker: RTL and testbench
======================================

# nand3_sweep_checker

Self-checking stimulus stage placed directly upstream of the 3-input NAND gate. On a start pulse it drives the gate inputs through all eight combinations 000→111, holds each for a programmable number of cycles, and samples the gate output on the final hold cycle. Each sample is compared against an internally computed NAND. It reports completion, pass/fail, the error count and the first failing vector.

## Interface
- `HOLD_CYCLES`, default 5: cycles each vector is held before `y` is sampled; legal range 1..255.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: single-cycle pulse; starts a sweep when idle.
- `y` in 1: gate output under test.
- `a` out 1: gate input, MSB of the current vector.
- `b` out 1: gate input, middle bit of the current vector.
- `c` out 1: gate input, LSB of the current vector.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse at the end of a sweep.
- `pass` out 1: 1 when the last sweep had zero mismatches; held until the next start.
- `err_count` out 4: mismatches in the last sweep, range 0..8.
- `fail_vec` out 3: {a,b,c} of the first mismatching vector; 000 if none.
- `fail_valid` out 1: high when `fail_vec` holds a real failure.

## Operation
- States:
  - IDLE: `busy`=0, {a,b,c}=000.
  - HOLD: applies the vector, counts hold cycles.
  - FINISH: asserts `done` for one cycle, returns to IDLE.
- Transitions:
  - IDLE→HOLD on `start`=1. On that edge, vector=000, hold counter=0, `err_count`=0, `fail_valid`=0, `fail_vec`=000, `pass`=0.
  - HOLD: the hold counter increments each cycle. When it reaches HOLD_CYCLES-1, that edge samples `y` and compares it to expected = ~(a&b&c).
    - On mismatch, `err_count` increments.
    - On the first mismatch, {a,b,c} is captured into `fail_vec` and `fail_valid` is set.
    - On the same edge, the vector increments and the counter clears.
    - If the vector was 111, the FSM goes to FINISH instead.
  - FINISH: `done`=1 and `busy`=0 for this cycle. `pass` = (`err_count`==0), including the 111 compare result. Next state is IDLE and {a,b,c} returns to 000.
- Width and arithmetic:
  - The vector is a 3-bit counter; wrap-around past 111 never occurs because 111 terminates the sweep.
  - `err_count` is 4 bits and cannot overflow (max 8).
  - The hold counter is 8 bits.
- Boundary conditions:
  - `start` while `busy`=1 or in FINISH: ignored.
  - `start` in the same cycle the FSM returns to IDLE: ignored.
  - `y` not 0/1 (X/Z) at the sample edge counts as a mismatch.
  - `rst_n` low at any time, including mid-sweep: immediate return to IDLE. All outputs go to their reset values; the partial sweep is discarded with no `done`.
- Reset values: `a`=`b`=`c`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=000, `fail_valid`=0.

## Timing
- The first vector 000 appears one cycle after the `start` sample edge.
- Each vector is stable for exactly HOLD_CYCLES cycles; `y` is sampled at the last edge of that window.
- The gate must settle within HOLD_CYCLES-1 cycles (combinational gate: HOLD_CYCLES=1 is valid).
- Latency from the `start` edge to `done` high: 8×HOLD_CYCLES+1 cycles (41 at default).
- All outputs are registered; no combinational path from `y` or `start` to any output.

## Configuration
- `SWEEP_STOP_ON_FAIL_EN` defined:
  - On the first mismatch the FSM goes directly to FINISH after the compare edge.
  - `err_count` is then 1, `pass`=0, and `fail_vec` holds the failing vector.
  - {a,b,c} returns to 000 in IDLE.
- Not defined: the sweep always covers all 8 vectors and counts every mismatch.

## Test plan
- Correct NAND3 connected, HOLD_CYCLES=5:
  - `start` pulse → vectors 000..111 each held 5 cycles.
  - `done` exactly 41 cycles after the start edge, `pass`=1, `err_count`=0, `fail_valid`=0.
- Gate replaced by AND3 (inverted output):
  - `err_count`=8, `pass`=0, `fail_vec`=000, `fail_valid`=1.
  - With `SWEEP_STOP_ON_FAIL_EN`: `done` after 6 cycles, `err_count`=1.
- `y` stuck at 1:
  - Only vector 111 mismatches → `err_count`=1, `fail_vec`=111, `pass`=0.
- `rst_n` pulled low during vector 011:
  - Outputs reset asynchronously, no `done`.
  - After release, a new `start` sweeps from 000 and passes.
- `start` re-pulsed at cycle 10 of a sweep and in the FINISH cycle:
  - Both ignored; a single `done`; sweep timing unchanged.
- HOLD_CYCLES=1 with a correct gate:
  - `done` 9 cycles after start, `pass`=1.

Source files
------------

// File: rtl/nand3_sweep_checker.sv
// Stimulus/checker stage for a 3-input NAND gate: sweeps 000..111, samples y, reports pass/fail.
// Optional build macro SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module nand3_sweep_checker #(
  parameter int HOLD_CYCLES = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       y_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [3:0] err_count_o,
  output logic [2:0] fail_vec_o,
  output logic       fail_valid_o
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FINISH
  } state_e;

  localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] holdCnt_q, holdCnt_d;
  logic [3:0] errCount_q, errCount_d;
  logic [2:0] failVec_q, failVec_d;
  logic       failValid_q, failValid_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic expected;
  logic mismatch;
  logic sampleEdge;
  logic startAccept;
  logic stopNow;

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    holdCnt_d   = holdCnt_q;
    errCount_d  = errCount_q;
    failVec_d   = failVec_q;
    failValid_d = failValid_q;
    pass_d      = pass_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    expected    = ~(&vec_q);
    // Case inequality so an X/Z gate output is scored as a mismatch.
    mismatch    = (y_i !== expected);
    sampleEdge  = (state_q == HOLD) && (holdCnt_q == HoldLast);
    // The cycle with done high is still the tail of the sweep, so start is refused there.
    startAccept = (state_q == IDLE) && start_i && !done_q;
`ifdef SWEEP_STOP_ON_FAIL_EN
    stopNow     = mismatch;
`else
    stopNow     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (startAccept) begin
          state_d     = HOLD;
          vec_d       = 3'd0;
          holdCnt_d   = 8'd0;
          errCount_d  = 4'd0;
          failVec_d   = 3'd0;
          failValid_d = 1'b0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
        end
      end
      HOLD: begin
        holdCnt_d = holdCnt_q + 8'd1;
        if (sampleEdge) begin
          holdCnt_d = 8'd0;
          vec_d     = vec_q + 3'd1;
          if (mismatch) begin
            errCount_d = errCount_q + 4'd1;
            if (!failValid_q) begin
              failVec_d   = vec_q;
              failValid_d = 1'b1;
            end
          end
          if (vec_q == 3'd7 || stopNow) begin
            state_d = FINISH;
            vec_d   = 3'd0;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (errCount_q == 4'd0);
      end
      default: begin
        state_d = IDLE;
        vec_d   = 3'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      vec_q       <= 3'd0;
      holdCnt_q   <= 8'd0;
      errCount_q  <= 4'd0;
      failVec_q   <= 3'd0;
      failValid_q <= 1'b0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      holdCnt_q   <= holdCnt_d;
      errCount_q  <= errCount_d;
      failVec_q   <= failVec_d;
      failValid_q <= failValid_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign a_o          = vec_q[2];
  assign b_o          = vec_q[1];
  assign c_o          = vec_q[0];
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign err_count_o  = errCount_q;
  assign fail_vec_o   = failVec_q;
  assign fail_valid_o = failValid_q;

endmodule

// File: tb/tb_nand3_sweep_checker.sv
// Bench for nand3_sweep_checker: two instances (HOLD 5 and 1) driving a faultable NAND3 model,
// checked every cycle against a time-indexed sweep model.
module tb_nand3_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start[2];
  logic [7:0] mask[2];
  logic       y[2];
  logic       a[2], b[2], c[2];
  logic       busy[2], done[2], pass[2], failValid[2];
  logic [3:0] errCount[2];
  logic [2:0] failVec[2];

  int checks   = 0;
  int failures = 0;

  nand3_sweep_checker #(.HOLD_CYCLES(5)) dut5 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .y_i(y[0]),
    .a_o(a[0]), .b_o(b[0]), .c_o(c[0]), .busy_o(busy[0]), .done_o(done[0]),
    .pass_o(pass[0]), .err_count_o(errCount[0]), .fail_vec_o(failVec[0]),
    .fail_valid_o(failValid[0])
  );

  nand3_sweep_checker #(.HOLD_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .y_i(y[1]),
    .a_o(a[1]), .b_o(b[1]), .c_o(c[1]), .busy_o(busy[1]), .done_o(done[1]),
    .pass_o(pass[1]), .err_count_o(errCount[1]), .fail_vec_o(failVec[1]),
    .fail_valid_o(failValid[1])
  );

  // Gate under test: a true NAND3 with the output flipped for every vector set in mask.
  assign y[0] = ~(a[0] & b[0] & c[0]) ^ mask[0][{a[0], b[0], c[0]}];
  assign y[1] = ~(a[1] & b[1] & c[1]) ^ mask[1][{a[1], b[1], c[1]}];

  function automatic int holdOf(input int d);
    return (d == 0) ? 5 : 1;
  endfunction

  function automatic int firstFail(input logic [7:0] m);
    for (int j = 0; j < 8; j++) if (m[j]) return j;
    return 8;
  endfunction

  function automatic int nVec(input logic [7:0] m);
`ifdef SWEEP_STOP_ON_FAIL_EN
    if (firstFail(m) < 8) return firstFail(m) + 1;
`endif
    return 8;
  endfunction

  // Model: t counts clock edges since the accepted start edge.
  bit         active[2];
  bit         ran[2];
  int         t[2];
  logic [7:0] sweepMask[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        active[d] <= 1'b0;
        ran[d]    <= 1'b0;
        t[d]      <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (active[d]) begin
          if (t[d] == nVec(sweepMask[d]) * holdOf(d) + 1) active[d] <= 1'b0;
          else t[d] <= t[d] + 1;
        end else if (start[d]) begin
          active[d]    <= 1'b1;
          ran[d]       <= 1'b1;
          t[d]         <= 0;
          sweepMask[d] <= mask[d];
        end
      end
    end
  end

  task automatic expectedOutputs(input int d, output int eVec, output int eBusy,
                                 output int eDone, output int ePass, output int eErr,
                                 output int eFv, output int eFvalid);
    int h, n, tt, completed;
    eVec = 0; eBusy = 0; eDone = 0; ePass = 0; eErr = 0; eFv = 0; eFvalid = 0;
    if (ran[d]) begin
      h  = holdOf(d);
      n  = nVec(sweepMask[d]);
      tt = active[d] ? t[d] : n * h + 1;
      completed = tt / h;
      if (completed > n) completed = n;
      for (int j = 0; j < completed; j++) begin
        if (sweepMask[d][j]) begin
          if (eFvalid == 0) eFv = j;
          eFvalid = 1;
          eErr++;
        end
      end
      if (active[d] && tt < n * h) eVec = tt / h;
      eBusy = (active[d] && tt <= n * h) ? 1 : 0;
      eDone = (active[d] && tt == n * h + 1) ? 1 : 0;
      ePass = (tt == n * h + 1 && eErr == 0) ? 1 : 0;
    end
  endtask

  task automatic checkOutput(input string name, input int d, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s dut%0d: got %0d, expected %0d", name, d, actual, expected);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int eVec, eBusy, eDone, ePass, eErr, eFv, eFvalid;
      expectedOutputs(d, eVec, eBusy, eDone, ePass, eErr, eFv, eFvalid);
      checkOutput("abc", d, int'({a[d], b[d], c[d]}), eVec);
      checkOutput("busy", d, int'(busy[d]), eBusy);
      checkOutput("done", d, int'(done[d]), eDone);
      checkOutput("pass", d, int'(pass[d]), ePass);
      checkOutput("errCount", d, int'(errCount[d]), eErr);
      checkOutput("failVec", d, int'(failVec[d]), eFv);
      checkOutput("failValid", d, int'(failValid[d]), eFvalid);
    end
  end

  // Pulses start and returns edges from the start edge to done high; optionally re-pulses start
  // mid-sweep and across the finish/done cycles.
  task automatic applyStimulus(input int d, input logic [7:0] m, input bit repulse, output int lat);
    @(negedge clk);
    mask[d]  = m;
    start[d] = 1'b1;
    @(posedge clk);
    #1 start[d] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk);
      #1;
      if (repulse && (k == 9 || k == 8 * holdOf(d))) start[d] = 1'b1;
      if (repulse && k == 10) start[d] = 1'b0;
      if (done[d]) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) checkOutput("doneTimeout", d, 0, 1);
    @(posedge clk);
    #1 start[d] = 1'b0;
  endtask

  task automatic countDones(input int d, input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done[d]) n++;
    end
  endtask

  initial begin
    int lat, nd, d;
    logic [7:0] m;
    rst_n    = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    mask[0]  = 8'h00;
    mask[1]  = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    checkOutput("resetBusy", 0, int'(busy[0]), 0);
    checkOutput("resetPass", 0, int'(pass[0]), 0);

    applyStimulus(0, 8'h00, 1'b0, lat);
    checkOutput("latencyGood", 0, lat, 41);
    checkOutput("passGood", 0, int'(pass[0]), 1);
    checkOutput("errGood", 0, int'(errCount[0]), 0);
    checkOutput("fvalidGood", 0, int'(failValid[0]), 0);

    applyStimulus(0, 8'hFF, 1'b0, lat);
`ifdef SWEEP_STOP_ON_FAIL_EN
    checkOutput("latencyAnd3", 0, lat, 6);
    checkOutput("errAnd3", 0, int'(errCount[0]), 1);
`else
    checkOutput("latencyAnd3", 0, lat, 41);
    checkOutput("errAnd3", 0, int'(errCount[0]), 8);
`endif
    checkOutput("passAnd3", 0, int'(pass[0]), 0);
    checkOutput("fvecAnd3", 0, int'(failVec[0]), 0);
    checkOutput("fvalidAnd3", 0, int'(failValid[0]), 1);

    applyStimulus(0, 8'h80, 1'b0, lat);
    checkOutput("latencyStuck1", 0, lat, 41);
    checkOutput("errStuck1", 0, int'(errCount[0]), 1);
    checkOutput("fvecStuck1", 0, int'(failVec[0]), 7);
    checkOutput("passStuck1", 0, int'(pass[0]), 0);

    // Reset asserted mid-cycle while vector 011 is applied.
    @(negedge clk);
    mask[0]  = 8'h00;
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (17) @(posedge clk);
    #1 checkOutput("vec011", 0, int'({a[0], b[0], c[0]}), 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncRstBusy", 0, int'(busy[0]), 0);
    checkOutput("asyncRstVec", 0, int'({a[0], b[0], c[0]}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    countDones(0, 60, nd);
    checkOutput("noDoneAfterReset", 0, nd, 0);
    applyStimulus(0, 8'h00, 1'b0, lat);
    checkOutput("latencyAfterReset", 0, lat, 41);
    checkOutput("passAfterReset", 0, int'(pass[0]), 1);

    applyStimulus(0, 8'h00, 1'b1, lat);
    checkOutput("latencyRepulse", 0, lat, 41);
    countDones(0, 60, nd);
    checkOutput("singleDone", 0, nd, 0);

    applyStimulus(1, 8'h00, 1'b0, lat);
    checkOutput("latencyHold1", 1, lat, 9);
    checkOutput("passHold1", 1, int'(pass[1]), 1);

    for (int i = 0; i < 24; i++) begin
      d = int'($urandom_range(0, 1));
      m = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      applyStimulus(d, m, 1'($urandom_range(0, 1)), lat);
      checkOutput("latencyRandom", d, lat, nVec(m) * holdOf(d) + 1);
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
